// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache.
// Optional hit/miss counters behind DCACHE_STATS_EN.
module dcache_2way #(
  parameter int ADDR_W      = 8,
  parameter int SETS        = 4,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          address,
  input  logic [7:0]                 writedata,
  output logic [7:0]                 readdata,
  output logic                       busywait,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0] mem_address,
  output logic [8*BLOCK_BYTES-1:0]   mem_writedata,
  input  logic [8*BLOCK_BYTES-1:0]   mem_readdata,
`ifdef DCACHE_STATS_EN
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count,
`endif
  input  logic                       mem_busywait
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 8 * BLOCK_BYTES;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  logic [BLK_W-1:0] data_q [SETS][2];
  logic [TAG_W-1:0] tag_q  [SETS][2];
  logic [1:0]       valid_q [SETS];
  logic [1:0]       dirty_q [SETS];
  logic [SETS-1:0]  lru_q;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       vic_q;
  logic       vic_c;

  logic [TAG_W-1:0] tag_a;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             hit0;
  logic             hit1;
  logic             hit;
  logic             req;
  logic             do_wr;
  logic             idle_hit;
  logic             idle_miss;
  logic             fill;
  logic [BLK_W-1:0] hit_blk;

  assign tag_a = address[ADDR_W-1 -: TAG_W];
  assign idx   = address[OFF_W +: IDX_W];
  assign off   = address[OFF_W-1:0];

  assign hit0 = valid_q[idx][0] &&
                (tag_q[idx][0] == tag_a);
  assign hit1 = valid_q[idx][1] &&
                (tag_q[idx][1] == tag_a);
  assign hit  = hit0 | hit1;

  assign req   = read | write;
  assign do_wr = write & ~read;

  assign idle_hit  = (state_q == IDLE) & req & hit;
  assign idle_miss = (state_q == IDLE) & req & ~hit;
  assign fill      = (state_q == ALLOCATE) & ~mem_busywait;

  assign busywait = req & ~((state_q == IDLE) & hit);

  assign hit_blk  = hit1 ? data_q[idx][1]
                         : data_q[idx][0];
  assign readdata = hit_blk[{off, 3'b000} +: 8];

  // Prefer an empty way, else the least recently used one.
  always_comb begin
    vic_c = lru_q[idx];
    if (!valid_q[idx][0])
      vic_c = 1'b0;
    else if (!valid_q[idx][1])
      vic_c = 1'b1;
  end

  // Controller next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (idle_miss)
          state_d = (valid_q[idx][vic_c] &&
                     dirty_q[idx][vic_c])
                    ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (!mem_busywait)
          state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (!mem_busywait)
          state_d = UPDATE;
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request signals, quiet outside transfers.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state_q)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[idx][vic_q], idx};
        mem_writedata = data_q[idx][vic_q];
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {tag_a, idx};
      end
      default: ;
    endcase
  end

  // FSM state, victim latch and per-line status bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vic_q   <= 1'b0;
      lru_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
    end else begin
      state_q <= state_d;
      if (idle_hit) begin
        lru_q[idx] <= ~hit1;
        if (do_wr)
          dirty_q[idx][hit1] <= 1'b1;
      end
      if (idle_miss)
        vic_q <= vic_c;
      if (state_q == UPDATE) begin
        valid_q[idx][vic_q] <= 1'b1;
        dirty_q[idx][vic_q] <= 1'b0;
      end
    end
  end

  // Data and tag arrays; contents qualified by valid.
  always_ff @(posedge clock) begin
    if (idle_hit && do_wr)
      data_q[idx][hit1][{off, 3'b000} +: 8]
        <= writedata;
    if (fill)
      data_q[idx][vic_q] <= mem_readdata;
    if (state_q == UPDATE)
      tag_q[idx][vic_q] <= tag_a;
  end

`ifdef DCACHE_STATS_EN
  logic after_upd_q;

  // Saturating hit/miss counters; the post-refill hit is not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      after_upd_q <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      after_upd_q <= (state_q == UPDATE);
      if (idle_hit && !after_upd_q &&
          hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (idle_miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the block-wide data memory. Generalises the direct-mapped 8-line cache: configurable set count, block size and address width, with per-set LRU replacement and a single registered controller FSM handling write-back and refill. Hits complete with no stall; misses stall the CPU through `busywait` until the refill is installed.

## Interface
- `ADDR_W`, 8: CPU byte-address width.
- `SETS`, 4: number of sets; power of two, ≥2. `IDX_W = log2(SETS)`.
- `BLOCK_BYTES`, 4: bytes per block; power of two, ≥2. `OFF_W = log2(BLOCK_BYTES)`, `TAG_W = ADDR_W-IDX_W-OFF_W`.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `read` in 1: CPU load request, held until `busywait` low.
- `write` in 1: CPU store request, held until `busywait` low.
- `address` in ADDR_W: byte address = {tag, index, offset}.
- `writedata` in 8: store byte.
- `readdata` out 8: load byte, combinational from the hitting way.
- `busywait` out 1: CPU stall.
- `mem_read` out 1: block read request.
- `mem_write` out 1: block write request.
- `mem_address` out ADDR_W-OFF_W: block address {tag, index}.
- `mem_writedata` out 8*BLOCK_BYTES: victim block; byte k at bits [8k+7:8k].
- `mem_readdata` in 8*BLOCK_BYTES: refill block.
- `mem_busywait` in 1: memory busy; must be high in the same cycle a request is first raised and fall for the completion cycle.

## Operation
- Storage per set, per way: data block, tag, valid, dirty; one LRU bit per set (way index of least-recently used).
- Hit: `valid[w] && tag[w]==addr tag` for w in {0,1}; both ways never hold the same valid tag.
- `read && write` both high is treated as a read.
- FSM states: IDLE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE, request, hit: read returns byte `offset` of hit way; write stores byte at posedge, sets dirty. LRU[set] ← other way. Stay IDLE.
- IDLE, request, miss: victim = invalid way if any (way 0 if both invalid), else LRU way. Victim latched. Dirty valid victim → WRITEBACK; else → ALLOCATE.
- WRITEBACK: `mem_write`=1, `mem_address`={victim tag, index}, `mem_writedata`=victim block. Exit to ALLOCATE on posedge with `mem_busywait`=0.
- ALLOCATE: `mem_read`=1, `mem_address`={request tag, index}. Exit to UPDATE on posedge with `mem_busywait`=0, capturing `mem_readdata` into the victim way.
- UPDATE: victim way valid=1, dirty=0, tag=request tag written; → IDLE. The next cycle is a normal hit, which performs the load or store.
- `mem_read` and `mem_write` are never high together; both are 0 in IDLE and UPDATE.

## Timing
- `busywait` = (`read`|`write`) & !(state==IDLE & hit); combinational, low with no request.
- Hit latency: 0 stall cycles; store written at the first posedge of the request.
- Clean miss: ALLOCATE (≥1 cycle, plus memory latency) + UPDATE (1) + hit cycle.
- Dirty miss: adds WRITEBACK (≥1 cycle, plus memory latency).
- Reset values: state IDLE; all valid, dirty and LRU = 0; `mem_read`=`mem_write`=0; `mem_address` and `mem_writedata`=0; `readdata` is don't-care with no hit.
- Reset mid-miss: the in-flight memory transaction is abandoned and the cache is empty on release. The memory side must be reset with it.
- Request change while stalled: illegal; the CPU holds `address`, `read`, `write` and `writedata` until `busywait` falls.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count` (16) and `miss_count` (16), reset to 0 and saturating at 16'hFFFF.
  - `miss_count` increments on each IDLE→WRITEBACK/ALLOCATE transition.
  - `hit_count` increments on each IDLE hit completion that is not the first cycle after UPDATE.
- `DCACHE_STATS_EN` undefined: no counters and no such ports; behaviour otherwise identical.

## Test plan
Defaults: index = addr[3:2], tag = addr[7:4].
- Reset, then read 0x14 → ALLOCATE with `mem_address`=0x05; memory returns 0xDDCCBBAA → after UPDATE, `readdata`=0xAA and `busywait` falls; no WRITEBACK.
- Write 0x55 to 0x15 after the previous scenario → zero-stall hit; a subsequent read of 0x15 returns 0x55, with way 0 of set 1 dirty.
- Read 0x24 (set 1 miss, way 1 invalid) → fill way 1, no writeback. Then read 0x34 → LRU victim is way 0 (dirty) → WRITEBACK with `mem_address`=0x05, `mem_writedata`=0xDDCC55AA, then ALLOCATE 0x0D.
- Alternating reads 0x24/0x34 after the previous scenario → all hits; LRU toggles; `mem_read` stays 0.
- Pull `reset` low during ALLOCATE → `mem_read` drops asynchronously; after release, read 0x14 misses again.
- With `DCACHE_STATS_EN`: the first scenario followed by 3 repeated reads of 0x14 → `miss_count`=1, `hit_count`=3.
